// File: rtl/interval_meter_if.sv
// interval_meter_if: measurement control, result handshake and status bundle
interface interval_meter_if #(parameter int WIDTH = 8);
  logic             start_flag;
  logic             stop_flag;
  logic             result_ack;
  logic [WIDTH-1:0] measure_value;
  logic             measure_valid;
  logic             measure_overflow;
  logic             busy;
  modport master (
    output start_flag, stop_flag, result_ack,
    input  measure_value, measure_valid, measure_overflow, busy
  );
  modport slave (
    input  start_flag, stop_flag, result_ack,
    output measure_value, measure_valid, measure_overflow, busy
  );
endinterface

// File: rtl/interval_meter.sv
// interval_meter: counts CLK edges from start to stop, result via valid/ack with saturating overflow
module interval_meter #(parameter int WIDTH = 8) (
  input logic         CLK,
  input logic         RST,
  interval_meter_if.slave m
);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  localparam logic [WIDTH-1:0] SAT = {{(WIDTH-1){1'b1}}, 1'b0};
  state_t           state;
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state              <= IDLE;
      cnt                <= '0;
      m.measure_value    <= '0;
      m.measure_valid    <= 1'b0;
      m.measure_overflow <= 1'b0;
      m.busy             <= 1'b0;
    end else begin
      case (state)
        IDLE: if (m.start_flag) begin
          state  <= COUNT;
          cnt    <= '0;
          m.busy <= 1'b1;
        end
        COUNT: if (m.stop_flag) begin
          state              <= HOLD;
          m.measure_value    <= cnt + WIDTH'(1);
          m.measure_valid    <= 1'b1;
          m.measure_overflow <= 1'b0;
        end else if (cnt == SAT) begin
          state              <= HOLD;
          m.measure_value    <= '1;
          m.measure_valid    <= 1'b1;
          m.measure_overflow <= 1'b1;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
        HOLD: if (m.result_ack) begin
          m.measure_valid <= 1'b0;
          if (m.start_flag) begin
            state <= COUNT;
            cnt   <= '0;
          end else begin
            state              <= IDLE;
            m.measure_overflow <= 1'b0;
            m.busy             <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interval_meter.sv
// tb_interval_meter: directed scenario tasks with hand-computed expectations
module tb_interval_meter;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int checks = 0;
  int errors = 0;
  interval_meter_if #(.WIDTH(8)) bus ();
  interval_meter #(.WIDTH(8)) dut (.CLK(CLK), .RST(RST), .m(bus));
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic pulse_start();
    bus.start_flag = 1'b1;
    step();
    bus.start_flag = 1'b0;
  endtask
  task automatic pulse_stop();
    bus.stop_flag = 1'b1;
    step();
    bus.stop_flag = 1'b0;
  endtask
  task automatic pulse_ack();
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
  endtask
  task automatic test_reset();
    bus.start_flag = 1'b0;
    bus.stop_flag  = 1'b0;
    bus.result_ack = 1'b0;
    #3;
    checks++;
    if ({bus.measure_value, bus.measure_valid, bus.measure_overflow, bus.busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {bus.measure_value, bus.measure_valid, bus.measure_overflow, bus.busy});
    end
    step();
    step();
    RST = 1'b1;
    step();
    pulse_start();
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy_before got %b exp 1", bus.busy); end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({bus.measure_value, bus.measure_valid, bus.measure_overflow, bus.busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async got %h exp 0", {bus.measure_value, bus.measure_valid, bus.measure_overflow, bus.busy});
    end
    step();
    RST = 1'b1;
    pulse_stop();
    step();
    checks++;
    if ({bus.measure_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_result got valid=%b busy=%b exp 0 0", bus.measure_valid, bus.busy);
    end
  endtask
  task automatic test_basic();
    pulse_start();
    repeat (4) step();
    checks++;
    if (bus.measure_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", bus.measure_valid); end
    pulse_stop();
    checks++;
    if ({bus.measure_valid, bus.measure_overflow, bus.busy, bus.measure_value} !== {3'b101, 8'd5}) begin
      errors++;
      $display("FAIL basic_result got v=%b o=%b b=%b val=%0d exp 1 0 1 5", bus.measure_valid, bus.measure_overflow, bus.busy, bus.measure_value);
    end
    repeat (3) step();
    checks++;
    if ({bus.measure_valid, bus.measure_value} !== {1'b1, 8'd5}) begin
      errors++;
      $display("FAIL basic_held got v=%b val=%0d exp 1 5", bus.measure_valid, bus.measure_value);
    end
    pulse_ack();
    checks++;
    if ({bus.measure_valid, bus.busy, bus.measure_value} !== {2'b00, 8'd5}) begin
      errors++;
      $display("FAIL basic_ack got v=%b b=%b val=%0d exp 0 0 5", bus.measure_valid, bus.busy, bus.measure_value);
    end
  endtask
  task automatic test_loopback();
    logic [7:0] timer_circle = 8'd20;
    pulse_start();
    repeat (int'(timer_circle)) step();
    pulse_stop();
    checks++;
    if ({bus.measure_valid, bus.measure_overflow, bus.measure_value} !== {2'b10, 8'd21}) begin
      errors++;
      $display("FAIL loopback got v=%b o=%b val=%0d exp 1 0 21", bus.measure_valid, bus.measure_overflow, bus.measure_value);
    end
    pulse_ack();
  endtask
  task automatic test_saturation();
    pulse_start();
    repeat (254) step();
    checks++;
    if (bus.measure_valid !== 1'b0) begin errors++; $display("FAIL sat_early got v=%b exp 0", bus.measure_valid); end
    step();
    checks++;
    if ({bus.measure_valid, bus.measure_overflow, bus.measure_value} !== {2'b11, 8'd255}) begin
      errors++;
      $display("FAIL sat_overflow got v=%b o=%b val=%0d exp 1 1 255", bus.measure_valid, bus.measure_overflow, bus.measure_value);
    end
    pulse_ack();
    checks++;
    if ({bus.measure_valid, bus.measure_overflow, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL sat_ack_clear got v=%b o=%b b=%b exp 0 0 0", bus.measure_valid, bus.measure_overflow, bus.busy);
    end
    pulse_start();
    repeat (254) step();
    pulse_stop();
    checks++;
    if ({bus.measure_valid, bus.measure_overflow, bus.measure_value} !== {2'b10, 8'd255}) begin
      errors++;
      $display("FAIL sat_exact_stop got v=%b o=%b val=%0d exp 1 0 255", bus.measure_valid, bus.measure_overflow, bus.measure_value);
    end
    pulse_ack();
  endtask
  task automatic test_back_to_back();
    pulse_start();
    repeat (4) step();
    pulse_stop();
    bus.result_ack = 1'b1;
    bus.start_flag = 1'b1;
    step();
    bus.result_ack = 1'b0;
    bus.start_flag = 1'b0;
    checks++;
    if ({bus.measure_valid, bus.busy, bus.measure_value} !== {2'b01, 8'd5}) begin
      errors++;
      $display("FAIL b2b_restart got v=%b b=%b val=%0d exp 0 1 5", bus.measure_valid, bus.busy, bus.measure_value);
    end
    repeat (2) step();
    pulse_stop();
    checks++;
    if ({bus.measure_valid, bus.busy, bus.measure_value} !== {2'b11, 8'd3}) begin
      errors++;
      $display("FAIL b2b_result got v=%b b=%b val=%0d exp 1 1 3", bus.measure_valid, bus.busy, bus.measure_value);
    end
    pulse_ack();
  endtask
  task automatic test_ignored();
    pulse_stop();
    pulse_ack();
    checks++;
    if ({bus.measure_valid, bus.busy, bus.measure_value} !== {2'b00, 8'd3}) begin
      errors++;
      $display("FAIL ign_idle got v=%b b=%b val=%0d exp 0 0 3", bus.measure_valid, bus.busy, bus.measure_value);
    end
    bus.start_flag = 1'b1;
    bus.stop_flag  = 1'b1;
    step();
    bus.start_flag = 1'b0;
    bus.stop_flag  = 1'b0;
    checks++;
    if ({bus.measure_valid, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL ign_start_stop got v=%b b=%b exp 0 1", bus.measure_valid, bus.busy);
    end
    pulse_start();
    repeat (2) step();
    pulse_stop();
    checks++;
    if ({bus.measure_valid, bus.measure_value} !== {1'b1, 8'd4}) begin
      errors++;
      $display("FAIL ign_start_in_count got v=%b val=%0d exp 1 4", bus.measure_valid, bus.measure_value);
    end
    pulse_start();
    pulse_stop();
    checks++;
    if ({bus.measure_valid, bus.busy, bus.measure_value} !== {2'b11, 8'd4}) begin
      errors++;
      $display("FAIL ign_hold got v=%b b=%b val=%0d exp 1 1 4", bus.measure_valid, bus.busy, bus.measure_value);
    end
    pulse_ack();
    step();
    checks++;
    if ({bus.measure_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL ign_start_lost got v=%b b=%b exp 0 0", bus.measure_valid, bus.busy);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_saturation();
    test_back_to_back();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
